cr16_controller: RTL
====================

Name: cr16_controller

Overview:
- Multicycle control unit directly upstream of the 16-bit datapath.
- Holds the instruction register and the processor status flags (PSR).
- Sequences fetch, decode, execute and memory states, and drives every datapath mux select, enable and register address.
- One instruction completes before the next fetch begins; there is no overlap.

Parameters:
WIDTH, 16, instruction/data width
REG_ADD, 4, register-file address width
IMM, 8, immediate field width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-low; sampled on rising clk
mem_out  in  WIDTH  memory read data (1-cycle synchronous read)
flags_in  in  3  ALU flags {C,N,Z} for the current alucont/operands
ra1  out  REG_ADD  ir[3:0], Rsrc/Raddr/Rtarget field
ra2  out  REG_ADD  ir[11:8], Rdest field
wa  out  REG_ADD  ir[11:8], write address
imm  out  IMM  ir[7:0]
regwrite, memwrite, pcen  out  1 each  write enables
pc_s, mem_s  out  1 each  0=Rsrc, 1=alu_out / 0=Rsrc, 1=pc
wd_s  out  2  0=imm, 1=Rsrc, 2=mem_out, 3=alu_out
alua_s  out  2  0=Rsrc, 1=pc, 2=imm_ext, 3=zero
alub_s  out  2  0=Rdest, 1=one, 2=imm_ext, 3=zero (datapath alub mux is mux4)
signext_sign  out  1  1=sign-extend imm, 0=zero-extend
alucont  out  3  000 ADD (A+B), 001 SUB (B−A), 010 AND, 011 OR, 100 XOR
psr  out  3  latched {C,N,Z}
state  out  4  current FSM state (debug)

Behaviour:
Reset:
- While reset=0 at a clk edge: state←FETCH, ir←0, psr←0.
- Every output is combinational from state/ir. All enables are 0 outside the states listed below.
- Reset asserted mid-instruction aborts it. The next cycle is FETCH, and no regwrite, memwrite or pcen pulse appears in the cycle reset is low.

Instruction decode (op=ir[15:12], ext=ir[7:4]):
- R-type: op 0000 with ext ADD 0101 / SUB 1001 / CMP 1011 / AND 0001 / OR 0010 / XOR 0011 / MOV 1101.
- Immediate forms: op equal to the ext code above. ADDI/SUBI/CMPI sign-extend; ANDI/ORI/XORI/MOVI zero-extend.
- op 0100: LOAD (ext 0000), STOR (ext 0100), Jcond (ext 1100; cond=ir[11:8]).
- Bcond: op 1100, cond=ir[11:8], disp=ir[7:0] signed.
- Anything else is illegal: treated as NOP, DECODE→FETCH.

States (encoding in parentheses):
- FETCH(0): mem_s=1, alua_s=1, alub_s=1, ADD, pc_s=1, pcen=1 (pc←pc+1). →FWAIT.
- FWAIT(1): ir←mem_out. →DECODE.
- DECODE(2): regfile read is latched by the datapath.
  - ALU ops →EXEC.
  - LOAD→LD_ADDR; STOR→STORE.
  - Bcond taken→BRANCH, not taken→FETCH.
  - Jcond taken→JUMP, not taken→FETCH.
- EXEC(3):
  - R-type: alua_s=0, alub_s=0.
  - Immediate: alua_s=2, alub_s=0.
  - wd_s=3, regwrite=1 except CMP/CMPI.
  - MOV: wd_s=1. MOVI: wd_s=0, zero-extended.
  - →FETCH.
- LD_ADDR(4): mem_s=0. →LD_WB.
- LD_WB(5): wd_s=2, regwrite=1. →FETCH.
- STORE(6): mem_s=0, memwrite=1 for exactly 1 cycle (data = Rdest). →FETCH.
- BRANCH(7): alua_s=1, alub_s=2, signext_sign=1, ADD, pc_s=1, pcen=1. Target is pc_next+disp. →FETCH.
- JUMP(8): pc_s=0, pcen=1. →FETCH.

PSR update (end of EXEC only):
- ADD/SUB/CMP families update C,N,Z from flags_in.
- AND/OR/XOR families update N,Z; C is held.
- MOV/MOVI, loads, stores and branches leave psr unchanged.

Condition codes (evaluated from psr in DECODE):
- 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 LT N; 0101 GE !N; 1110 UC always.
- All other codes are never taken.

Latency:
- ALU 4 cycles, LOAD 5, STOR 4.
- Taken branch/jump 4 cycles, not taken 3.

Optional Feature:
- Macro CTRL_JAL_EN.
- When defined: JAL (op 0100, ext 1000, Rlink=ir[11:8], Rtarget=ir[3:0]) decodes to JAL_LINK(9).
  - JAL_LINK(9): alua_s=1, alub_s=3, ADD, wd_s=3, regwrite=1. →JUMP.
  - Total 5 cycles.
- When undefined: that encoding is illegal (NOP) and state 9 does not exist.

Test Plan:
- Reset low for 2 cycles while in EXEC of ADD → state=0 next cycle, regwrite never asserted, psr=0; release → FETCH with pcen=1.
- mem_out=0x0553 (ADD r5,r3) → state sequence 0,1,2,3. In state 3: regwrite=1, wa=5, ra1=3, wd_s=3, alucont=000. flags_in=3'b001 → psr=001.
- 0x4207 (LOAD r2,[r7]) → states 0,1,2,4,5. mem_s=0 in states 4–5. State 5: regwrite=1, wd_s=2, wa=2.
- CMP with flags_in Z=1, then 0xC0FE (BEQ −2) → BRANCH with alua_s=1, alub_s=2, signext_sign=1, pcen=1. Repeat with Z=0 → DECODE→FETCH, single pcen pulse (in FETCH).
- 0x4345 (STOR r3,[r5]) → memwrite high exactly one cycle in state 6, regwrite=0 throughout.
- 0xF000 illegal → states 0,1,2,0; no regwrite/memwrite. With CTRL_JAL_EN, 0x4A86 → states 0,1,2,9,8 with wa=10 and pc_s=0 in state 8.

Source files
------------

// File: rtl/cr16_controller_if.sv
// cr16_controller_if: control/status bundle between the
// cr16 controller (master) and its 16-bit datapath (slave).
interface cr16_controller_if #(
  parameter int WIDTH   = 16,
  parameter int REG_ADD = 4,
  parameter int IMM     = 8
);
  logic [WIDTH-1:0]   mem_out;
  logic [2:0]         flags_in;
  logic [REG_ADD-1:0] ra1;
  logic [REG_ADD-1:0] ra2;
  logic [REG_ADD-1:0] wa;
  logic [IMM-1:0]     imm;
  logic               regwrite;
  logic               memwrite;
  logic               pcen;
  logic               pc_s;
  logic               mem_s;
  logic [1:0]         wd_s;
  logic [1:0]         alua_s;
  logic [1:0]         alub_s;
  logic               signext_sign;
  logic [2:0]         alucont;
  logic [2:0]         psr;
  logic [3:0]         state;

  modport master (
    input  mem_out, flags_in,
    output ra1, ra2, wa, imm,
    output regwrite, memwrite, pcen,
    output pc_s, mem_s, wd_s,
    output alua_s, alub_s,
    output signext_sign, alucont,
    output psr, state
  );

  modport slave (
    output mem_out, flags_in,
    input  ra1, ra2, wa, imm,
    input  regwrite, memwrite, pcen,
    input  pc_s, mem_s, wd_s,
    input  alua_s, alub_s,
    input  signext_sign, alucont,
    input  psr, state
  );
endinterface

// File: rtl/cr16_controller.sv
// cr16_controller: multicycle control unit with IR and PSR.
// Optional JAL instruction enabled by macro CTRL_JAL_EN.
module cr16_controller #(
  parameter int WIDTH   = 16,
  parameter int REG_ADD = 4,
  parameter int IMM     = 8
) (
  input logic clk,
  input logic reset,
  cr16_controller_if.master bus
);
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_FWAIT   = 4'd1,
    S_DECODE  = 4'd2,
    S_EXEC    = 4'd3,
    S_LD_ADDR = 4'd4,
    S_LD_WB   = 4'd5,
    S_STORE   = 4'd6,
    S_BRANCH  = 4'd7,
`ifdef CTRL_JAL_EN
    S_JUMP    = 4'd8,
    S_JAL     = 4'd9
`else
    S_JUMP    = 4'd8
`endif
  } state_e;

  typedef enum logic [2:0] {
    K_ADD, K_SUB, K_CMP, K_AND,
    K_OR, K_XOR, K_MOV, K_NONE
  } kind_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] ir_q, ir_d;
  logic [2:0]       psr_q, psr_d;

  logic [3:0] op, ext, cond, code;
  logic       is_r, is_alu, is_ld, is_st;
  logic       is_b, is_jc, taken;
  kind_e      kind;
  logic       rw, mw, pe;

  assign op   = ir_q[15:12];
  assign ext  = ir_q[7:4];
  assign cond = ir_q[11:8];
  assign is_r = (op == 4'b0000);
  // R-type keys on ext, immediate forms reuse it as op
  assign code = is_r ? ext : op;

  assign is_ld = (op == 4'b0100) && (ext == 4'b0000);
  assign is_st = (op == 4'b0100) && (ext == 4'b0100);
  assign is_jc = (op == 4'b0100) && (ext == 4'b1100);
  assign is_b  = (op == 4'b1100);

`ifdef CTRL_JAL_EN
  logic is_jal;
  assign is_jal = (op == 4'b0100) && (ext == 4'b1000);
`endif

  // ALU-family classification of the held instruction
  always_comb begin
    kind = K_NONE;
    case (code)
      4'b0101: kind = K_ADD;
      4'b1001: kind = K_SUB;
      4'b1011: kind = K_CMP;
      4'b0001: kind = K_AND;
      4'b0010: kind = K_OR;
      4'b0011: kind = K_XOR;
      4'b1101: kind = K_MOV;
      default: kind = K_NONE;
    endcase
  end

  assign is_alu = (kind != K_NONE);

  // condition code test against psr {C,N,Z}
  always_comb begin
    taken = 1'b0;
    case (cond)
      4'b0000: taken = psr_q[0];
      4'b0001: taken = !psr_q[0];
      4'b0010: taken = psr_q[2];
      4'b0011: taken = !psr_q[2];
      4'b0100: taken = psr_q[1];
      4'b0101: taken = !psr_q[1];
      4'b1110: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  // state, IR and PSR registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_FETCH;
      ir_q    <= '0;
      psr_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      psr_q   <= psr_d;
    end
  end

  // next state, register updates and datapath controls
  always_comb begin
    state_d          = state_q;
    ir_d             = ir_q;
    psr_d            = psr_q;
    rw               = 1'b0;
    mw               = 1'b0;
    pe               = 1'b0;
    bus.pc_s         = 1'b0;
    bus.mem_s        = 1'b0;
    bus.wd_s         = 2'd0;
    bus.alua_s       = 2'd0;
    bus.alub_s       = 2'd0;
    bus.signext_sign = 1'b0;
    bus.alucont      = 3'b000;
    unique case (state_q)
      S_FETCH: begin
        bus.mem_s  = 1'b1;
        bus.alua_s = 2'd1;
        bus.alub_s = 2'd1;
        bus.pc_s   = 1'b1;
        pe         = 1'b1;
        state_d    = S_FWAIT;
      end
      S_FWAIT: begin
        ir_d    = bus.mem_out;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        unique case (1'b1)
          is_alu:  state_d = S_EXEC;
          is_ld:   state_d = S_LD_ADDR;
          is_st:   state_d = S_STORE;
          is_b:    state_d = taken ? S_BRANCH : S_FETCH;
          is_jc:   state_d = taken ? S_JUMP : S_FETCH;
`ifdef CTRL_JAL_EN
          is_jal:  state_d = S_JAL;
`endif
          default: state_d = S_FETCH;
        endcase
      end
      S_EXEC: begin
        bus.alua_s = is_r ? 2'd0 : 2'd2;
        bus.signext_sign = !is_r &&
          (kind inside {K_ADD, K_SUB, K_CMP});
        bus.wd_s = 2'd3;
        rw       = (kind != K_CMP);
        unique case (kind)
          K_ADD: begin
            bus.alucont = 3'b000;
            psr_d       = bus.flags_in;
          end
          K_SUB, K_CMP: begin
            bus.alucont = 3'b001;
            psr_d       = bus.flags_in;
          end
          K_AND: begin
            bus.alucont = 3'b010;
            psr_d = {psr_q[2], bus.flags_in[1:0]};
          end
          K_OR: begin
            bus.alucont = 3'b011;
            psr_d = {psr_q[2], bus.flags_in[1:0]};
          end
          K_XOR: begin
            bus.alucont = 3'b100;
            psr_d = {psr_q[2], bus.flags_in[1:0]};
          end
          K_MOV:   bus.wd_s = is_r ? 2'd1 : 2'd0;
          default: rw = 1'b0;
        endcase
        state_d = S_FETCH;
      end
      S_LD_ADDR: state_d = S_LD_WB;
      S_LD_WB: begin
        bus.wd_s = 2'd2;
        rw       = 1'b1;
        state_d  = S_FETCH;
      end
      S_STORE: begin
        mw      = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        bus.alua_s       = 2'd1;
        bus.alub_s       = 2'd2;
        bus.signext_sign = 1'b1;
        bus.pc_s         = 1'b1;
        pe               = 1'b1;
        state_d          = S_FETCH;
      end
      S_JUMP: begin
        pe      = 1'b1;
        state_d = S_FETCH;
      end
`ifdef CTRL_JAL_EN
      S_JAL: begin
        bus.alua_s = 2'd1;
        bus.alub_s = 2'd3;
        bus.wd_s   = 2'd3;
        rw         = 1'b1;
        state_d    = S_JUMP;
      end
`endif
      default: state_d = S_FETCH;
    endcase
  end

  // a low reset squashes any write pulse of the aborted state
  assign bus.regwrite = rw & reset;
  assign bus.memwrite = mw & reset;
  assign bus.pcen     = pe & reset;

  assign bus.ra1   = ir_q[3:0];
  assign bus.ra2   = ir_q[11:8];
  assign bus.wa    = ir_q[11:8];
  assign bus.imm   = ir_q[7:0];
  assign bus.psr   = psr_q;
  assign bus.state = state_q;
endmodule
